uart_i2c_cmd: RTL and testbench
===============================

// Module: uart_i2c_cmd
// PURPOSE
//  UART-to-I2C command bridge between a UART (AXI-Stream byte in/out) and an I2C master (cmd + data streams).
//  Takes a 2-byte command frame from UART RX and runs the matching I2C write or register read.
//  Returns read data, or an error code, over UART TX.
// PARAMETERS
//  ERR_CODE     8'hEE  byte sent on UART TX when the I2C master reports missed_ack
//  RD_LEN_CONV  2      bytes read when conversion flag=1 (flag=0 reads 1 byte)
// PORTS
//  clk                   in   1  system clock
//  rstn                  in   1  asynchronous active-low reset
//  tx_busy               in   1  UART transmitter busy
//  s_tdata               out  8  byte to UART TX
//  s_tvalid              out  1  s_tdata valid
//  s_tready              in   1  UART TX ready
//  m_tdata               in   8  byte from UART RX
//  m_tvalid              in   1  m_tdata valid
//  m_tready              out  1  accept RX byte
//  rx_busy               in   1  UART receiving a frame
//  rx_overrun_error      in   1  UART RX overrun (pulse)
//  rx_frame_error        in   1  UART RX bad stop bit (pulse)
//  s_cmd_Addr            out  7  I2C target address
//  s_cmd_start           out  1  force (repeated) start
//  s_cmd_read            out  1  read-one-byte command
//  s_cmd_write           out  1  single-byte write command (held 0)
//  s_cmd_write_multiple  out  1  streamed write command, ends on tlast
//  s_cmd_stop            out  1  issue stop after command
//  s_cmd_valid           out  1  command valid
//  s_cmd_ready           in   1  master accepts command
//  s_cmd_tdata           out  8  write data to master
//  s_cmd_tvalid          out  1  write data valid
//  s_cmd_tready          in   1  master accepts write data
//  s_cmd_tlast           out  1  last write byte
//  m_cmd_tdata           in   8  read data from master
//  m_cmd_tvalid          in   1  read data valid
//  m_cmd_tready          out  1  accept read data
//  m_cmd_tlast           in   1  last read byte (ignored)
//  missed_ack            in   1  master saw NACK (pulse)
// BEHAVIOUR
//  Frame: byte0={addr[6:0],rw}; byte1={conv,reg[6:0]}. rw=0 write, rw=1 read.
//  Reset: all outputs 0 except m_tready=1; FSM->IDLE; regs cleared. Reset mid-op aborts immediately.
//  Handshakes: AXI-S; transfer when valid&ready; valid held, payload stable until accepted.
//  Controls: cmd fields constant while s_cmd_valid=1. s_tvalid rises only when tx_busy=0.
//  IDLE: m_tready=1; byte latched -> addr,rw; ->GET_REG.
//  GET_REG: m_tready=1; byte latched -> conv,reg; rw=0->WR_CMD, rw=1->PTR_CMD.
//   rx_overrun_error|rx_frame_error in IDLE/GET_REG drops partial frame -> IDLE.
//  WR_CMD: s_cmd_valid, write_multiple=1, start=1, stop=1; accepted -> WR_DATA.
//  WR_DATA: s_cmd_tdata=byte1 (all 8 bits), tvalid=1, tlast=1; accepted -> IDLE.
//  PTR_CMD: write_multiple=1, start=1, stop=0 -> PTR_DATA: tdata={1'b0,reg}, tlast=1 -> RD_CMD.
//  RD_CMD: read=1, start=1 on first byte only; stop=1 on last (count=RD_LEN_CONV if conv else 1).
//   Accepted -> RD_WAIT.
//  RD_WAIT: m_cmd_tready=1; byte to 16-bit buffer, MSB first -> RD_CMD, or TX_RESP after last.
//  TX_RESP: send buffered bytes in read order on s_tdata -> IDLE.
//  RX bytes during any non-IDLE/GET_REG state: m_tready=0 (back-pressure, not dropped).
//  missed_ack in any I2C state: drop pending valids, send ERR_CODE once -> IDLE.
//   Master issues its own stop.
//  Simultaneous: reset > missed_ack > handshake completion.
// TESTING
//  rx 0x9A,0xBB -> one cmd: addr 0x4D, write_multiple=1, start=1, stop=1; data 0xBB tlast=1; no TX.
//  rx 0x9F,0x83 -> ptr write 0x4F data 0x03 stop=0; 2 reads, stop on 2nd.
//   Master returns 0x12,0x34 -> UART TX 0x12 then 0x34.
//  rx 0x9F,0x05 -> ptr 0x05; one read with start=1, stop=1; 1 TX byte.
//  missed_ack during WR_CMD of 0x9A,0xBB -> TX 0xEE; next frame handled normally.
//  rx 0x9A then rx_frame_error -> frame dropped; then 0x9A,0x11 -> write 0x11 to addr 0x4D.
//  rstn low mid read -> outputs at reset values within a cycle, m_tready=1, no TX.

Source files
------------

// File: rtl/uart_i2c_cmd.sv
// rtl/uart_i2c_cmd.sv - UART-to-I2C command bridge: 2-byte frame in, I2C write or register read, response out.
module uart_i2c_cmd #(
    parameter logic [7:0]  ERR_CODE    = 8'hEE,
    parameter int unsigned RD_LEN_CONV = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_busy,
    output logic [7:0] s_tdata,
    output logic       s_tvalid,
    input  logic       s_tready,
    input  logic [7:0] m_tdata,
    input  logic       m_tvalid,
    output logic       m_tready,
    input  logic       rx_busy,
    input  logic       rx_overrun_error,
    input  logic       rx_frame_error,
    output logic [6:0] s_cmd_Addr,
    output logic       s_cmd_start,
    output logic       s_cmd_read,
    output logic       s_cmd_write,
    output logic       s_cmd_write_multiple,
    output logic       s_cmd_stop,
    output logic       s_cmd_valid,
    input  logic       s_cmd_ready,
    output logic [7:0] s_cmd_tdata,
    output logic       s_cmd_tvalid,
    input  logic       s_cmd_tready,
    output logic       s_cmd_tlast,
    input  logic [7:0] m_cmd_tdata,
    input  logic       m_cmd_tvalid,
    output logic       m_cmd_tready,
    input  logic       m_cmd_tlast,
    input  logic       missed_ack
);
    typedef enum logic [3:0] {
        IDLE, GET_REG, WR_CMD, WR_DATA, PTR_CMD, PTR_DATA, RD_CMD, RD_WAIT, TX_RESP, TX_ERR
    } state_t;

    localparam logic [1:0] CONV_LEN = 2'(RD_LEN_CONV);

    state_t      state_q;
    logic [6:0]  addr_q;
    logic        rw_q;
    logic [7:0]  wbyte_q;
    logic [1:0]  rd_total_q, rd_cnt_q, tx_left_q;
    logic [15:0] buf_q;
    logic [7:0]  s_tdata_q, s_cmd_tdata_q;
    logic        s_tvalid_q, m_tready_q, m_cmd_tready_q;
    logic        s_cmd_start_q, s_cmd_read_q, s_cmd_wm_q, s_cmd_stop_q, s_cmd_valid_q;
    logic        s_cmd_tvalid_q, s_cmd_tlast_q;

    logic rx_err, i2c_state;
    logic unused_inputs;

    assign rx_err    = rx_overrun_error | rx_frame_error;
    assign i2c_state = (state_q == WR_CMD) || (state_q == WR_DATA) || (state_q == PTR_CMD) ||
                       (state_q == PTR_DATA) || (state_q == RD_CMD) || (state_q == RD_WAIT);
    // Read data carries no framing of its own and rx_busy adds nothing beyond m_tvalid.
    assign unused_inputs = m_cmd_tlast ^ rx_busy;

    assign s_tdata              = s_tdata_q;
    assign s_tvalid             = s_tvalid_q;
    assign m_tready             = m_tready_q;
    assign s_cmd_Addr           = addr_q;
    assign s_cmd_start          = s_cmd_start_q;
    assign s_cmd_read           = s_cmd_read_q;
    assign s_cmd_write          = 1'b0;
    assign s_cmd_write_multiple = s_cmd_wm_q;
    assign s_cmd_stop           = s_cmd_stop_q;
    assign s_cmd_valid          = s_cmd_valid_q;
    assign s_cmd_tdata          = s_cmd_tdata_q;
    assign s_cmd_tvalid         = s_cmd_tvalid_q;
    assign s_cmd_tlast          = s_cmd_tlast_q;
    assign m_cmd_tready         = m_cmd_tready_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            rw_q           <= 1'b0;
            wbyte_q        <= '0;
            rd_total_q     <= '0;
            rd_cnt_q       <= '0;
            tx_left_q      <= '0;
            buf_q          <= '0;
            s_tdata_q      <= '0;
            s_cmd_tdata_q  <= '0;
            s_tvalid_q     <= 1'b0;
            m_tready_q     <= 1'b1;
            m_cmd_tready_q <= 1'b0;
            s_cmd_start_q  <= 1'b0;
            s_cmd_read_q   <= 1'b0;
            s_cmd_wm_q     <= 1'b0;
            s_cmd_stop_q   <= 1'b0;
            s_cmd_valid_q  <= 1'b0;
            s_cmd_tvalid_q <= 1'b0;
            s_cmd_tlast_q  <= 1'b0;
        end else if (i2c_state && missed_ack) begin
            // The master issues its own stop; we only abandon the transfer and report it.
            s_cmd_valid_q  <= 1'b0;
            s_cmd_tvalid_q <= 1'b0;
            s_cmd_tlast_q  <= 1'b0;
            m_cmd_tready_q <= 1'b0;
            state_q        <= TX_ERR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_err && m_tvalid && m_tready_q) begin
                        addr_q  <= m_tdata[7:1];
                        rw_q    <= m_tdata[0];
                        state_q <= GET_REG;
                    end
                end
                GET_REG: begin
                    if (rx_err) begin
                        state_q <= IDLE;
                    end else if (m_tvalid && m_tready_q) begin
                        wbyte_q       <= m_tdata;
                        rd_total_q    <= m_tdata[7] ? CONV_LEN : 2'd1;
                        rd_cnt_q      <= '0;
                        m_tready_q    <= 1'b0;
                        s_cmd_valid_q <= 1'b1;
                        s_cmd_wm_q    <= 1'b1;
                        s_cmd_read_q  <= 1'b0;
                        s_cmd_start_q <= 1'b1;
                        s_cmd_stop_q  <= !rw_q;
                        state_q       <= rw_q ? PTR_CMD : WR_CMD;
                    end
                end
                WR_CMD, PTR_CMD: begin
                    if (s_cmd_ready) begin
                        s_cmd_valid_q  <= 1'b0;
                        s_cmd_tvalid_q <= 1'b1;
                        s_cmd_tlast_q  <= 1'b1;
                        s_cmd_tdata_q  <= (state_q == WR_CMD) ? wbyte_q : {1'b0, wbyte_q[6:0]};
                        state_q        <= (state_q == WR_CMD) ? WR_DATA : PTR_DATA;
                    end
                end
                WR_DATA: begin
                    if (s_cmd_tready) begin
                        s_cmd_tvalid_q <= 1'b0;
                        s_cmd_tlast_q  <= 1'b0;
                        m_tready_q     <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                PTR_DATA: begin
                    if (s_cmd_tready) begin
                        s_cmd_tvalid_q <= 1'b0;
                        s_cmd_tlast_q  <= 1'b0;
                        s_cmd_valid_q  <= 1'b1;
                        s_cmd_wm_q     <= 1'b0;
                        s_cmd_read_q   <= 1'b1;
                        s_cmd_start_q  <= 1'b1;
                        s_cmd_stop_q   <= (rd_total_q == 2'd1);
                        state_q        <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (s_cmd_ready) begin
                        s_cmd_valid_q  <= 1'b0;
                        m_cmd_tready_q <= 1'b1;
                        state_q        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (m_cmd_tvalid) begin
                        buf_q          <= {buf_q[7:0], m_cmd_tdata};
                        rd_cnt_q       <= rd_cnt_q + 2'd1;
                        m_cmd_tready_q <= 1'b0;
                        if (rd_cnt_q + 2'd1 == rd_total_q) begin
                            tx_left_q <= rd_total_q;
                            state_q   <= TX_RESP;
                        end else begin
                            s_cmd_valid_q <= 1'b1;
                            s_cmd_start_q <= 1'b0;
                            s_cmd_stop_q  <= (rd_cnt_q + 2'd2 == rd_total_q);
                            state_q       <= RD_CMD;
                        end
                    end
                end
                TX_RESP, TX_ERR: begin
                    if (s_tvalid_q) begin
                        if (s_tready) begin
                            s_tvalid_q <= 1'b0;
                            tx_left_q  <= tx_left_q - 2'd1;
                            if (state_q == TX_ERR || tx_left_q == 2'd1) begin
                                m_tready_q <= 1'b1;
                                state_q    <= IDLE;
                            end
                        end
                    end else if (!tx_busy) begin
                        s_tvalid_q <= 1'b1;
                        // First-read byte sits in the upper half once two bytes are buffered.
                        if (state_q == TX_ERR)       s_tdata_q <= ERR_CODE;
                        else if (tx_left_q == 2'd2)  s_tdata_q <= buf_q[15:8];
                        else                         s_tdata_q <= buf_q[7:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_i2c_cmd.sv
// tb/tb_uart_i2c_cmd.sv - scoreboard bench for uart_i2c_cmd with a randomized I2C master/UART TX model.
module tb_uart_i2c_cmd;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       tx_busy, s_tvalid, s_tready, m_tvalid, m_tready, rx_busy;
    logic [7:0] s_tdata, m_tdata, s_cmd_tdata, m_cmd_tdata;
    logic       rx_overrun_error, rx_frame_error;
    logic [6:0] s_cmd_Addr;
    logic       s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple, s_cmd_stop;
    logic       s_cmd_valid, s_cmd_ready, s_cmd_tvalid, s_cmd_tready, s_cmd_tlast;
    logic       m_cmd_tvalid, m_cmd_tready, m_cmd_tlast, missed_ack;

    uart_i2c_cmd dut (
        .clk(clk), .rstn(rstn), .tx_busy(tx_busy),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .rx_busy(rx_busy), .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
        .s_cmd_Addr(s_cmd_Addr), .s_cmd_start(s_cmd_start), .s_cmd_read(s_cmd_read),
        .s_cmd_write(s_cmd_write), .s_cmd_write_multiple(s_cmd_write_multiple),
        .s_cmd_stop(s_cmd_stop), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
        .s_cmd_tlast(s_cmd_tlast), .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid),
        .m_cmd_tready(m_cmd_tready), .m_cmd_tlast(m_cmd_tlast), .missed_ack(missed_ack)
    );

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_cmd[$];
    logic [8:0]  exp_dat[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  rd_src[$];

    bit nack_mode = 1'b0;
    bit hold_rd = 1'b0;
    int rd_pend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h expected=none", name, act);
    endtask

    function automatic logic [11:0] mk_cmd(input logic [6:0] a, input logic st, input logic rd,
                                           input logic wm, input logic sp);
        return {a, st, rd, 1'b0, wm, sp};
    endfunction

    // Monitors: a transfer is seen at the negedge preceding the edge that completes it.
    always @(negedge clk) begin
        if (rstn) begin
            if (s_cmd_valid && s_cmd_ready) begin
                if (exp_cmd.size() == 0)
                    unexpected("cmd_unexpected", {s_cmd_Addr, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple, s_cmd_stop});
                else
                    check("cmd_fields", {s_cmd_Addr, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple, s_cmd_stop}, exp_cmd.pop_front());
            end
            if (s_cmd_tvalid && s_cmd_tready) begin
                if (exp_dat.size() == 0)
                    unexpected("wdata_unexpected", {s_cmd_tdata, s_cmd_tlast});
                else
                    check("wdata", {s_cmd_tdata, s_cmd_tlast}, exp_dat.pop_front());
            end
            if (s_tvalid && s_tready) begin
                if (exp_tx.size() == 0)
                    unexpected("tx_unexpected", s_tdata);
                else
                    check("tx_byte", s_tdata, exp_tx.pop_front());
            end
        end
    end

    logic prev_tv = 1'b0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rstn && s_tvalid && !prev_tv)
            check("tvalid_rise_while_busy", prev_busy, 1'b0);
        prev_tv   <= s_tvalid;
        prev_busy <= tx_busy;
    end

    // I2C master and UART TX responder.
    bit cmd_hs_rd, rd_hs;
    initial begin
        s_cmd_ready = 0; s_cmd_tready = 0; m_cmd_tvalid = 0; m_cmd_tdata = 0;
        m_cmd_tlast = 0; s_tready = 0; tx_busy = 0;
        forever begin
            @(negedge clk);
            cmd_hs_rd = rstn && s_cmd_valid && s_cmd_ready && s_cmd_read;
            rd_hs     = m_cmd_tvalid && m_cmd_tready;
            @(posedge clk);
            #1;
            if (cmd_hs_rd) rd_pend++;
            if (rd_hs || !rstn) m_cmd_tvalid = 1'b0;
            if (!m_cmd_tvalid && rd_pend > 0 && !hold_rd && rd_src.size() > 0 && $urandom_range(0, 2) != 0) begin
                m_cmd_tdata  = rd_src.pop_front();
                m_cmd_tvalid = 1'b1;
                m_cmd_tlast  = 1'b1;
                rd_pend--;
            end
            s_cmd_ready  = !nack_mode && ($urandom_range(0, 2) != 0);
            s_cmd_tready = ($urandom_range(0, 2) != 0);
            s_tready     = ($urandom_range(0, 3) != 0);
            tx_busy      = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(posedge clk); #1;
        m_tdata  = b;
        m_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!m_tready && n < 1000);
        check("rx_accept", m_tready, 1'b1);
        @(posedge clk); #1;
        m_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_dat.size() != 0 || exp_tx.size() != 0 ||
                rd_src.size() != 0 || !m_tready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frame_done", n < 3000, 1'b1);
        repeat (3) @(posedge clk);
    endtask

    // Reference model: what one frame should produce on each output stream.
    task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] d0, input logic [7:0] d1, input bit nack);
        int n;
        if (nack) begin
            exp_tx.push_back(8'hEE);
        end else if (b0[0] == 1'b0) begin
            exp_cmd.push_back(mk_cmd(b0[7:1], 1, 0, 1, 1));
            exp_dat.push_back({b1, 1'b1});
        end else begin
            n = b1[7] ? 2 : 1;
            exp_cmd.push_back(mk_cmd(b0[7:1], 1, 0, 1, 0));
            exp_dat.push_back({1'b0, b1[6:0], 1'b1});
            for (int i = 0; i < n; i++) begin
                exp_cmd.push_back(mk_cmd(b0[7:1], i == 0, 1, 0, i == n - 1));
                rd_src.push_back(i == 0 ? d0 : d1);
                exp_tx.push_back(i == 0 ? d0 : d1);
            end
        end
    endtask

    task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] d0, input logic [7:0] d1, input bit nack);
        int n = 0;
        expect_frame(b0, b1, d0, d1, nack);
        nack_mode = nack;
        send_byte(b0);
        send_byte(b1);
        if (nack) begin
            while (!s_cmd_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("nack_cmd_pending", s_cmd_valid, 1'b1);
            @(posedge clk); #1;
            missed_ack = 1'b1;
            @(posedge clk); #1;
            missed_ack = 1'b0;
            nack_mode  = 1'b0;
            @(negedge clk);
            check("nack_cmd_dropped", s_cmd_valid, 1'b0);
        end
        wait_done();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        m_tdata = 0; m_tvalid = 0; rx_busy = 0;
        rx_overrun_error = 0; rx_frame_error = 0; missed_ack = 0;
        repeat (3) @(negedge clk);
        check("reset_m_tready", m_tready, 1'b1);
        check("reset_outs", {s_tvalid, s_cmd_valid, s_cmd_tvalid, m_cmd_tready, s_cmd_Addr}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        do_frame(8'h9A, 8'hBB, 8'h00, 8'h00, 0);
        do_frame(8'h9F, 8'h83, 8'h12, 8'h34, 0);
        do_frame(8'h9F, 8'h05, 8'h5C, 8'h00, 0);
        do_frame(8'h9A, 8'hBB, 8'h00, 8'h00, 1);
        do_frame(8'h9A, 8'h3C, 8'h00, 8'h00, 0);

        send_byte(8'h9A);
        @(posedge clk); #1;
        rx_frame_error = 1'b1;
        @(posedge clk); #1;
        rx_frame_error = 1'b0;
        do_frame(8'h9A, 8'h11, 8'h00, 8'h00, 0);

        // Reset while waiting on read data: nothing may be transmitted afterwards.
        hold_rd = 1'b1;
        exp_cmd.push_back(mk_cmd(7'h4F, 1, 0, 1, 0));
        exp_dat.push_back({8'h05, 1'b1});
        exp_cmd.push_back(mk_cmd(7'h4F, 1, 1, 0, 1));
        send_byte(8'h9F);
        send_byte(8'h05);
        n = 0;
        while (!m_cmd_tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rd_wait_reached", m_cmd_tready, 1'b1);
        check("rd_cmds_issued", exp_cmd.size() + exp_dat.size(), 0);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("midreset_m_tready", m_tready, 1'b1);
        check("midreset_outs", {s_tvalid, s_cmd_valid, s_cmd_tvalid, m_cmd_tready, s_cmd_read, s_cmd_Addr}, 0);
        repeat (3) @(posedge clk);
        rd_pend = 0;
        hold_rd = 1'b0;
        #1;
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_no_tx", s_tvalid, 1'b0);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] b0, b1, d0, d1;
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            do_frame(b0, b1, d0, d1, $urandom_range(0, 5) == 0);
        end

        check("end_queues_empty", exp_cmd.size() + exp_dat.size() + exp_tx.size() + rd_src.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
